counter_run_ctrl: RTL and testbench

- Control FSM that sequences a WIDTH-bit up-counter through programmed count runs.
- A requester hands over a terminal count via a valid/ready handshake; the block counts qualified enable pulses from 0 up to that target, then raises a one-cycle done pulse.
- Supports optional auto-reload (periodic runs) and abort.
- Sits between software/control logic and the counter datapath; the counter is fully synchronous on clk, with no rippled clocks.

---
 rtl/counter_run_ctrl.sv | 110 +++++++++++
 tb/tb_counter_run_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: sequences a WIDTH-bit up-counter through handshaked count runs
// with optional auto-reload and abort. Fully synchronous, active-low synchronous reset.
`default_nettype none

module counter_run_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_auto,
  input  logic             cnt_en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic             r_auto, w_auto_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic [WIDTH-1:0] w_count_inc;

  // Count never exceeds target, so the increment needs no carry.
  assign w_count_inc = r_count + C_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_count   <= C_ZERO;
      r_target  <= C_ZERO;
      r_auto    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_target  <= w_target_nxt;
      r_auto    <= w_auto_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_target_nxt  = r_target;
    w_auto_nxt    = r_auto;
    w_aborted_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_target_nxt = req_target;
          w_auto_nxt   = req_auto;
          w_count_nxt  = C_ZERO;
          w_state_nxt  = (req_target != C_ZERO) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_count_nxt   = C_ZERO;
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
        end else if (cnt_en) begin
          w_count_nxt = w_count_inc;
          if (w_count_inc == r_target) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          w_count_nxt   = C_ZERO;
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
        end else if (r_auto) begin
          w_count_nxt = C_ZERO;
          w_state_nxt = (r_target != C_ZERO) ? S_RUN : S_DONE;
        end else begin
          // count keeps showing the target until the next command is accepted
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = C_ZERO;
      end
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign count     = r_count;
  assign aborted   = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed and randomized stimulus checked against an
// event-level reference model of the run controller.
`default_nettype none

module tb_counter_run_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic             req_auto;
  logic             cnt_en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             aborted;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: a run is "active" while busy; "finished" marks the cycle
  // the run has reached its target (the done cycle).
  bit m_active;
  bit m_finished;
  bit m_abort_pulse;
  bit m_auto;
  int m_count;
  int m_target;

  counter_run_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_auto   (req_auto),
    .cnt_en     (cnt_en),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit s_rst, input bit s_valid, input int s_tgt,
                            input bit s_auto, input bit s_en, input bit s_abort);
    bit pulse;
    pulse = 1'b0;
    if (!s_rst) begin
      m_active = 0; m_finished = 0; m_count = 0; m_target = 0; m_auto = 0;
    end else if (!m_active) begin
      if (s_valid) begin
        m_target = s_tgt; m_auto = s_auto; m_count = 0;
        m_active = 1; m_finished = (s_tgt == 0);
      end
    end else if (m_finished) begin
      if (s_abort) begin
        m_active = 0; m_finished = 0; m_count = 0; pulse = 1'b1;
      end else if (m_auto) begin
        m_count = 0; m_finished = (m_target == 0);
      end else begin
        m_active = 0; m_finished = 0;
      end
    end else begin
      if (s_abort) begin
        m_active = 0; m_count = 0; pulse = 1'b1;
      end else if (s_en) begin
        m_count = m_count + 1;
        m_finished = (m_count == m_target);
      end
    end
    m_abort_pulse = pulse;
  endtask

  // One clock: sample inputs into the model, advance, then check away from the edge.
  task automatic cyc();
    bit s_rst, s_valid, s_auto, s_en, s_abort;
    int s_tgt;
    s_rst = rst; s_valid = req_valid; s_tgt = int'(req_target);
    s_auto = req_auto; s_en = cnt_en; s_abort = abort;
    @(posedge clk);
    model_edge(s_rst, s_valid, s_tgt, s_auto, s_en, s_abort);
    #1;
    chk("count",     32'(count),     32'(m_count));
    chk("busy",      32'(busy),      32'(m_active));
    chk("req_ready", 32'(req_ready), 32'(!m_active));
    chk("done",      32'(done),      32'(m_active && m_finished));
    chk("aborted",   32'(aborted),   32'(m_abort_pulse));
  endtask

  task automatic drive(input bit v, input int t, input bit a, input bit e, input bit ab);
    req_valid = v; req_target = WIDTH'(t); req_auto = a; cnt_en = e; abort = ab;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_active = 0; m_finished = 0; m_abort_pulse = 0; m_auto = 0; m_count = 0; m_target = 0;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Single run to 5
    drive(1, 5, 0, 1, 0); cyc();
    drive(0, 0, 0, 1, 0);
    repeat (7) cyc();

    // Gated counting to 3
    drive(1, 3, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    cnt_en = 0; cyc(); cyc();
    cnt_en = 1; cyc();
    cnt_en = 0; cyc();
    cnt_en = 1; cyc();
    cyc(); cyc();

    // Auto-reload on target 2, four periods, then abort at count 1
    drive(1, 2, 1, 1, 0); cyc();
    drive(0, 0, 0, 1, 0);
    repeat (12) cyc();
    cyc();
    abort = 1; cyc();
    abort = 0; repeat (4) cyc();

    // Full-scale target, no wrap
    drive(1, 15, 0, 1, 0); cyc();
    req_valid = 0;
    repeat (5) cyc();
    // Command offered mid-run must be ignored
    req_valid = 1; req_target = 4'd2; repeat (3) cyc();
    req_valid = 0; repeat (10) cyc();

    // Zero target, no auto
    drive(1, 0, 0, 0, 0); cyc();
    req_valid = 0; cyc(); cyc();
    // Abort while idle is ignored
    abort = 1; cyc(); abort = 0;

    // Reset mid-run at count 3 of 8, then an immediate new handshake
    drive(1, 8, 0, 1, 0); cyc();
    req_valid = 0; repeat (3) cyc();
    rst = 1'b0; cyc();
    rst = 1'b1;
    drive(1, 2, 0, 1, 0); cyc();
    req_valid = 0; repeat (4) cyc();

    // Zero target in auto mode, then abort during the done cycle
    drive(1, 0, 1, 0, 0); cyc();
    req_valid = 0; repeat (4) cyc();
    abort = 1; cyc(); abort = 0; cyc();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 99) != 0);
      req_valid  = ($urandom_range(0, 2) == 0);
      req_target = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 4))
                                              : WIDTH'($urandom_range(0, 15));
      req_auto   = ($urandom_range(0, 3) == 0);
      cnt_en     = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
